// File: rtl/mac_switch_pkg.sv
// Shared types and constants for the MAC-learning switch ingress path.
//   mac_t / port_t : MAC address and 3-bit switch port number
//   req_state_t    : per-port requester FSM states
//   fwd_dec_t      : forwarding decision presented to the fabric
//   mk_decision()  : maps a lookup result onto flood / drop / unicast
package mac_switch_pkg;

  typedef logic [47:0] mac_t;
  typedef logic [2:0]  port_t;

  localparam int   HDR_BYTES = 12;
  localparam mac_t BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    REQ,
    WAIT,
    PRESENT
  } req_state_t;

  typedef struct packed {
    port_t port;
    logic  flood;
    logic  drop;
  } fwd_dec_t;

  // Priority: group address or forced flood, then lookup miss, then hairpin.
  // A flood always carries the ingress port so the fabric can exclude it.
  function automatic fwd_dec_t mk_decision(logic  mcast,
                                           logic  force_flood,
                                           port_t res,
                                           port_t self_port,
                                           port_t miss_port);
    fwd_dec_t d;
    d.port  = res;
    d.flood = 1'b0;
    d.drop  = 1'b0;
    if (mcast || force_flood || (res == miss_port)) begin
      d.flood = 1'b1;
      d.port  = self_port;
    end else if (res == self_port) begin
      d.drop = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/mac_hdr_capture.sv
// Header capture for one ingress port: byte counter, destination/source MAC
// registers and header-error pulse generation.
//   clk, rst_n          : clock, async active-low reset
//   rx_*_i              : RX byte stream (sof/eof qualified by valid)
//   state_i             : requester FSM state (decides which bytes are taken)
//   dst_mac_o/src_mac_o : captured MACs, untouched outside IDLE/COLLECT
//   acc_o               : a header byte is taken this cycle
//   done_o              : header byte 11 is taken this cycle
//   runt_o              : eof arrived before byte 11
//   hdr_err_o           : registered one-cycle error pulse
module mac_hdr_capture
  import mac_switch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_sof_i,
  input  logic       rx_eof_i,
  input  req_state_t state_i,
  output mac_t       dst_mac_o,
  output mac_t       src_mac_o,
  output logic       acc_o,
  output logic       done_o,
  output logic       runt_o,
  output logic       hdr_err_o
);

  logic [3:0] cnt_q, cnt_d, idx;
  mac_t       dst_q, dst_d, src_q, src_d;
  logic       collecting, busy_st, restart, err_d, err_q;

  assign collecting = (state_i == COLLECT);
  assign busy_st    = (state_i == REQ) || (state_i == WAIT) || (state_i == PRESENT);

  // In IDLE only a sof byte opens a header; in COLLECT every valid byte counts.
  assign acc_o   = rx_valid_i && ((state_i == IDLE && rx_sof_i) || collecting);
  assign restart = collecting && rx_valid_i && rx_sof_i;
  assign idx     = rx_sof_i ? 4'd0 : cnt_q;
  assign done_o  = acc_o && (idx == 4'(HDR_BYTES - 1));
  assign runt_o  = acc_o && rx_eof_i && !done_o;

  // A sof while a request is outstanding is an overrun: that frame is dropped.
  assign err_d = runt_o || restart || (busy_st && rx_valid_i && rx_sof_i);

  always_comb begin
    dst_d = dst_q;
    src_d = src_q;
    cnt_d = cnt_q;
    if (acc_o) begin
      for (int i = 0; i < 6; i++) begin
        if (idx == 4'(i))     dst_d[8*(5-i) +: 8] = rx_data_i;
        if (idx == 4'(i + 6)) src_d[8*(5-i) +: 8] = rx_data_i;
      end
      cnt_d = (runt_o || done_o) ? 4'd0 : idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dst_q <= '0;
      src_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dst_q <= dst_d;
      src_q <= src_d;
      err_q <= err_d;
    end
  end

  assign dst_mac_o = dst_q;
  assign src_mac_o = src_q;
  assign hdr_err_o = err_q;

endmodule

// File: rtl/mac_lookup_requester.sv
// Per-port initiator for the shared mac_learning responder. Captures the
// dst/src MACs of each frame, issues one learn/lookup request (en/busy/done)
// and presents a forwarding decision to the fabric (valid/ready).
//   clk, rst_n            : clock, async active-low reset
//   rx_data/valid/sof/eof : RX MAC byte stream
//   ml_en, ml_*_mac       : request strobe and MACs (held until ml_done)
//   ml_src_port           : constant PORT_ID
//   ml_busy, ml_done      : responder flow control / response strobe
//   ml_dst_port           : responder result, sampled on ml_done
//   fwd_valid/port/flood/drop, fwd_ready : decision handshake
//   hdr_err, timeout_err  : one-cycle error pulses
module mac_lookup_requester
  import mac_switch_pkg::*;
#(
  parameter port_t       PORT_ID   = 3'd0,
  parameter int unsigned TIMEOUT   = 255,
  parameter port_t       MISS_PORT = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  output logic        ml_en,
  output logic [47:0] ml_src_mac,
  output logic [47:0] ml_dst_mac,
  output logic [2:0]  ml_src_port,
  input  logic        ml_busy,
  input  logic        ml_done,
  input  logic [2:0]  ml_dst_port,
  output logic        fwd_valid,
  output logic [2:0]  fwd_port,
  output logic        fwd_flood,
  output logic        fwd_drop,
  input  logic        fwd_ready,
  output logic        hdr_err,
  output logic        timeout_err
);

  req_state_t state_q;
  logic [7:0] timer_q;
  logic       ml_en_q, timeout_err_q, fwd_valid_q;
  fwd_dec_t   dec_q;
  mac_t       dst_mac, src_mac;
  logic       hdr_acc, hdr_done, hdr_runt;

  mac_hdr_capture u_cap (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .rx_sof_i  (rx_sof),
    .rx_eof_i  (rx_eof),
    .state_i   (state_q),
    .dst_mac_o (dst_mac),
    .src_mac_o (src_mac),
    .acc_o     (hdr_acc),
    .done_o    (hdr_done),
    .runt_o    (hdr_runt),
    .hdr_err_o (hdr_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      ml_en_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      fwd_valid_q   <= 1'b0;
      dec_q         <= '0;
    end else begin
      ml_en_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hdr_acc && !hdr_runt) state_q <= COLLECT;
        end
        COLLECT: begin
          if (hdr_runt) begin
            state_q <= IDLE;
          end else if (hdr_done) begin
            // Issue straight away when the responder is free so ml_en
            // follows the last header byte by one cycle.
            if (!ml_busy) begin
              ml_en_q <= 1'b1;
              timer_q <= '0;
              state_q <= WAIT;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (!ml_busy) begin
            ml_en_q <= 1'b1;
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // ml_done is checked first so a response on the final cycle wins.
          if (ml_done) begin
            dec_q       <= mk_decision(dst_mac[40], 1'b0, ml_dst_port, PORT_ID, MISS_PORT);
            fwd_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end else if (timer_q == 8'(TIMEOUT - 1)) begin
            dec_q         <= mk_decision(dst_mac[40], 1'b1, ml_dst_port, PORT_ID, MISS_PORT);
            fwd_valid_q   <= 1'b1;
            timeout_err_q <= 1'b1;
            state_q       <= PRESENT;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        PRESENT: begin
          if (fwd_ready) begin
            fwd_valid_q <= 1'b0;
            dec_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ml_en       = ml_en_q;
  assign ml_src_mac  = src_mac;
  assign ml_dst_mac  = dst_mac;
  assign ml_src_port = PORT_ID;
  assign fwd_valid   = fwd_valid_q;
  assign fwd_port    = dec_q.port;
  assign fwd_flood   = dec_q.flood;
  assign fwd_drop    = dec_q.drop;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mac_lookup_requester.sv
// Scenario-driven bench: each scenario is laid out as a per-cycle timeline of
// inputs, and the expected per-cycle outputs are derived from the frame timing
// (header end, busy length, response delay, ready delay) by plain arithmetic.
module tb_mac_lookup_requester;
  localparam int PID  = 2;
  localparam int TMO  = 20;
  localparam int MISS = 7;
  localparam int N    = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0;
  logic ml_en;
  logic [47:0] ml_src_mac, ml_dst_mac;
  logic [2:0] ml_src_port;
  logic ml_busy = 1'b0, ml_done = 1'b0;
  logic [2:0] ml_dst_port = '0;
  logic fwd_valid, fwd_flood, fwd_drop;
  logic [2:0] fwd_port;
  logic fwd_ready = 1'b0;
  logic hdr_err, timeout_err;

  int n_tests = 0, n_fail = 0;
  int cur_t = 0, len = 0;
  logic chk_on = 1'b0;

  // stimulus timeline
  logic [7:0] s_data [N];
  logic s_val [N], s_sof [N], s_eof [N], s_busy [N], s_done [N], s_rdy [N], s_rst [N];
  logic [2:0] s_dport [N];
  // expected timeline
  logic e_en [N], e_val [N], e_flood [N], e_drop [N], e_herr [N], e_terr [N], e_mchk [N];
  logic [2:0] e_port [N];
  logic [47:0] e_dst [N], e_src [N];

  // per-scenario observations used for literal pins
  int en_cnt, herr_cnt, terr_cnt;
  logic snap_got, snap_flood, snap_drop;
  logic [2:0] snap_port;
  logic [47:0] snap_dst;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  mac_lookup_requester #(.PORT_ID(3'(PID)), .TIMEOUT(TMO), .MISS_PORT(3'(MISS))) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .ml_en(ml_en), .ml_src_mac(ml_src_mac),
    .ml_dst_mac(ml_dst_mac), .ml_src_port(ml_src_port), .ml_busy(ml_busy),
    .ml_done(ml_done), .ml_dst_port(ml_dst_port), .fwd_valid(fwd_valid),
    .fwd_port(fwd_port), .fwd_flood(fwd_flood), .fwd_drop(fwd_drop),
    .fwd_ready(fwd_ready), .hdr_err(hdr_err), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, cur_t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ml_en", 48'(ml_en), 48'(e_en[cur_t]));
      chk("fwd_valid", 48'(fwd_valid), 48'(e_val[cur_t]));
      chk("hdr_err", 48'(hdr_err), 48'(e_herr[cur_t]));
      chk("timeout_err", 48'(timeout_err), 48'(e_terr[cur_t]));
      chk("ml_src_port", 48'(ml_src_port), 48'(PID));
      if (e_val[cur_t]) begin
        chk("fwd_port", 48'(fwd_port), 48'(e_port[cur_t]));
        chk("fwd_flood", 48'(fwd_flood), 48'(e_flood[cur_t]));
        chk("fwd_drop", 48'(fwd_drop), 48'(e_drop[cur_t]));
      end
      if (e_mchk[cur_t]) begin
        chk("ml_dst_mac", ml_dst_mac, e_dst[cur_t]);
        chk("ml_src_mac", ml_src_mac, e_src[cur_t]);
      end
      if (ml_en) begin en_cnt++; snap_dst = ml_dst_mac; end
      if (hdr_err) herr_cnt++;
      if (timeout_err) terr_cnt++;
      if (fwd_valid && !snap_got) begin
        snap_got = 1'b1; snap_port = fwd_port; snap_flood = fwd_flood; snap_drop = fwd_drop;
      end
    end
  end

  // g: idle lead-in, pre: junk bytes before a restarting sof, L: frame length,
  // B: busy cycles from the last header byte, D: ml_done delay after the
  // ml_en cycle (<0 = never), Rd: ready delay after fwd_valid rises,
  // ovr: second frame starts while the request is outstanding,
  // rst_rel: reset pulse this many cycles after the last header byte (<0 = none).
  task automatic build(input logic [47:0] dst, input logic [47:0] src, input int g,
                       input int pre, input int L, input int B, input int D, input int Rd,
                       input logic [2:0] res, input bit ovr, input int rst_rel);
    int t0, h, s, r, a, x, rst_at, last;
    logic to, fl, dr;
    logic [2:0] pt;
    x = 0;
    for (int t = 0; t < N; t++) begin
      s_data[t] = 8'($urandom); s_val[t] = 0; s_sof[t] = 0; s_eof[t] = 0;
      s_busy[t] = 0; s_done[t] = 0; s_rdy[t] = 0; s_rst[t] = 0; s_dport[t] = 3'($urandom);
      e_en[t] = 0; e_val[t] = 0; e_flood[t] = 0; e_drop[t] = 0; e_herr[t] = 0;
      e_terr[t] = 0; e_mchk[t] = 0; e_port[t] = '0; e_dst[t] = '0; e_src[t] = '0;
    end
    t0 = g;
    if (pre > 0) begin
      for (int i = 0; i < pre; i++) begin s_val[g+i] = 1; s_sof[g+i] = (i == 0); end
      t0 = g + pre;
      e_herr[t0+1] = 1;
    end
    for (int i = 0; i < L; i++) begin
      s_val[t0+i] = 1; s_sof[t0+i] = (i == 0); s_eof[t0+i] = (i == L-1);
      if (i < 6) s_data[t0+i] = dst[8*(5-i) +: 8];
      else if (i < 12) s_data[t0+i] = src[8*(11-i) +: 8];
    end
    s_done[t0+3] = 1;  // stray response during the header
    if (L < 12) begin
      e_herr[t0+L] = 1;
      len = t0 + L + 3;
      return;
    end
    h = t0 + 11;
    for (int i = 0; i < B; i++) s_busy[h+i] = 1;
    s = h + B;
    e_en[s+1] = 1;
    to = !(D >= 0 && D <= TMO-1);
    r = to ? s + TMO : s + 1 + D;
    if (D >= 0) begin s_done[s+1+D] = 1; s_dport[s+1+D] = res; end
    if (to) e_terr[r+1] = 1;
    fl = dst[40] | to | (res == 3'(MISS));
    dr = !fl && (res == 3'(PID));
    pt = fl ? 3'(PID) : res;
    a = r + 1 + Rd;
    s_rdy[a] = 1;
    s_rdy[h] = 1;
    for (int t = r+1; t <= a; t++) begin
      e_val[t] = 1; e_port[t] = pt; e_flood[t] = fl; e_drop[t] = dr;
    end
    for (int t = h+1; t <= a; t++) begin e_mchk[t] = 1; e_dst[t] = dst; e_src[t] = src; end
    if (ovr) begin
      x = h + 2;
      for (int i = 0; i < 5; i++) begin s_val[x+i] = 1; s_sof[x+i] = (i == 0); s_eof[x+i] = (i == 4); end
      e_herr[x+1] = 1;
    end
    last = t0 + L;
    if (a + 1 > last) last = a + 1;
    if (D >= 0 && s + 2 + D > last) last = s + 2 + D;
    if (ovr && x + 5 > last) last = x + 5;
    len = last + 2;
    if (len > N) len = N;
    if (rst_rel >= 0) begin
      rst_at = h + rst_rel;
      s_rst[rst_at] = 1;
      for (int t = rst_at; t < N; t++) begin
        e_en[t] = 0; e_val[t] = 0; e_terr[t] = 0; e_herr[t] = 0;
        e_mchk[t] = 1; e_dst[t] = '0; e_src[t] = '0;
      end
    end
  endtask

  task automatic run();
    for (int t = 0; t < len; t++) begin
      @(posedge clk); #1;
      cur_t = t;
      rx_data = s_data[t]; rx_valid = s_val[t]; rx_sof = s_sof[t]; rx_eof = s_eof[t];
      ml_busy = s_busy[t]; ml_done = s_done[t]; ml_dst_port = s_dport[t];
      fwd_ready = s_rdy[t]; rst_n = ~s_rst[t];
      chk_on = 1'b1;
    end
    @(posedge clk); #1;
    chk_on = 1'b0;
    rx_valid = 0; rx_sof = 0; rx_eof = 0; ml_busy = 0; ml_done = 0; fwd_ready = 0; rst_n = 1;
  endtask

  task automatic scen(input logic [47:0] dst, input logic [47:0] src, input int g,
                      input int pre, input int L, input int B, input int D, input int Rd,
                      input logic [2:0] res, input bit ovr, input int rst_rel);
    en_cnt = 0; herr_cnt = 0; terr_cnt = 0; snap_got = 0;
    snap_port = '0; snap_flood = 0; snap_drop = 0; snap_dst = '0;
    build(dst, src, g, pre, L, B, D, Rd, res, ovr, rst_rel);
    run();
  endtask

  initial begin
    logic [47:0] d, sm;
    int L, pre, D, B, Rd, g;
    bit ovr;
    logic [2:0] res;

    @(negedge clk);
    chk("rst ml_en", 48'(ml_en), 48'd0);
    chk("rst fwd_valid", 48'(fwd_valid), 48'd0);
    chk("rst fwd_port", 48'(fwd_port), 48'd0);
    chk("rst hdr_err", 48'(hdr_err), 48'd0);
    chk("rst timeout_err", 48'(timeout_err), 48'd0);
    chk("rst ml_dst_mac", ml_dst_mac, 48'd0);
    chk("rst ml_src_port", 48'(ml_src_port), 48'd2);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // unicast hit
    scen(48'h0200_0000_0005, 48'h0200_0000_000A, 1, 0, 60, 0, 4, 3, 3'd4, 1'b0, -1);
    chk("uni port", 48'(snap_port), 48'd4);
    chk("uni flood", 48'(snap_flood), 48'd0);
    chk("uni drop", 48'(snap_drop), 48'd0);
    chk("uni en_cnt", 48'(en_cnt), 48'd1);
    chk("uni req dst", snap_dst, 48'h0200_0000_0005);
    // broadcast
    scen(48'hFFFF_FFFF_FFFF, 48'h0200_0000_000A, 0, 0, 20, 0, 2, 0, 3'd3, 1'b0, -1);
    chk("bcast flood", 48'(snap_flood), 48'd1);
    chk("bcast port", 48'(snap_port), 48'd2);
    // lookup miss
    scen(48'h0200_0000_0009, 48'h0200_0000_000A, 2, 0, 14, 0, 1, 1, 3'd7, 1'b0, -1);
    chk("miss flood", 48'(snap_flood), 48'd1);
    // hairpin
    scen(48'h0200_0000_0002, 48'h0200_0000_000B, 0, 0, 12, 0, 3, 2, 3'd2, 1'b0, -1);
    chk("hairpin drop", 48'(snap_drop), 48'd1);
    chk("hairpin flood", 48'(snap_flood), 48'd0);
    // busy hold-off
    scen(48'h0200_0000_0005, 48'h0200_0000_000C, 1, 0, 16, 10, 2, 1, 3'd5, 1'b0, -1);
    chk("busy en_cnt", 48'(en_cnt), 48'd1);
    // runt, then the next scenario must work
    scen(48'h0200_0000_0005, 48'h0200_0000_000C, 1, 0, 8, 0, 2, 1, 3'd5, 1'b0, -1);
    chk("runt herr", 48'(herr_cnt), 48'd1);
    chk("runt en_cnt", 48'(en_cnt), 48'd0);
    chk("runt fwd", 48'(snap_got), 48'd0);
    // timeout
    scen(48'h0200_0000_0006, 48'h0200_0000_000D, 0, 0, 12, 0, -1, 2, 3'd4, 1'b0, -1);
    chk("tmo terr", 48'(terr_cnt), 48'd1);
    chk("tmo flood", 48'(snap_flood), 48'd1);
    chk("tmo port", 48'(snap_port), 48'd2);
    // ml_done on the timeout cycle
    scen(48'h0200_0000_0006, 48'h0200_0000_000D, 0, 0, 12, 0, TMO-1, 0, 3'd5, 1'b0, -1);
    chk("coin terr", 48'(terr_cnt), 48'd0);
    chk("coin port", 48'(snap_port), 48'd5);
    // reset during WAIT
    scen(48'h0200_0000_0006, 48'h0200_0000_000D, 0, 0, 12, 0, -1, 0, 3'd5, 1'b0, 5);
    chk("rst en_cnt", 48'(en_cnt), 48'd1);
    chk("rst fwd", 48'(snap_got), 48'd0);
    // restart mid-header, then overrun during the request
    scen(48'h0200_0000_0003, 48'h0200_0000_000E, 0, 4, 15, 0, 2, 0, 3'd3, 1'b0, -1);
    chk("restart herr", 48'(herr_cnt), 48'd1);
    chk("restart port", 48'(snap_port), 48'd3);
    scen(48'h0200_0000_0004, 48'h0200_0000_000F, 0, 0, 12, 1, 5, 1, 3'd1, 1'b1, -1);
    chk("ovr herr", 48'(herr_cnt), 48'd1);
    chk("ovr port", 48'(snap_port), 48'd1);

    for (int k = 0; k < 40; k++) begin
      d = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) d[40] = 1'b0;
      sm = {16'($urandom), 32'($urandom)};
      g = int'($urandom_range(0, 3));
      pre = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      ovr = ($urandom_range(0, 4) == 0);
      L = ovr ? 12 : int'($urandom_range(12, 30));
      if ($urandom_range(0, 7) == 0) begin L = int'($urandom_range(2, 11)); ovr = 0; end
      B = int'($urandom_range(0, 6));
      D = int'($urandom_range(0, 25));
      Rd = int'($urandom_range(0, 4));
      res = 3'($urandom);
      scen(d, sm, g, pre, L, B, D, Rd, res, ovr, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_lookup_requester.md
Name: mac_lookup_requester

Overview:
Per-port initiator for the mac_learning responder. It parses the first 12 bytes of each incoming Ethernet frame (destination MAC, then source MAC) from the port's byte stream. It issues one learn/lookup request per frame using the en/busy/done handshake, then presents a forwarding decision (port, flood or drop) to the switch fabric with a valid/ready handshake. One instance sits between each port's RX MAC and the shared mac_learning block.

Parameters:
PORT_ID, 0, 3-bit ingress port number driven on ml_src_port.
TIMEOUT, 255, max cycles in WAIT for ml_done before the request is abandoned; 8-bit counter, must be 1..255.
MISS_PORT, 7, ml_dst_port value that the responder returns for an unknown destination.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  frame byte
rx_valid  in  1  rx_data valid this cycle
rx_sof  in  1  first byte of frame; qualified by rx_valid
rx_eof  in  1  last byte of frame; qualified by rx_valid
ml_en  out  1  single-cycle request strobe to mac_learning
ml_src_mac  out  48  captured source MAC
ml_dst_mac  out  48  captured destination MAC
ml_src_port  out  3  constant PORT_ID
ml_busy  in  1  responder busy; no request may be issued while high
ml_done  in  1  single-cycle response strobe
ml_dst_port  in  3  responder result; sampled only when ml_done=1
fwd_valid  out  1  forwarding decision valid
fwd_port  out  3  egress port
fwd_flood  out  1  send to all ports except PORT_ID
fwd_drop  out  1  discard frame
fwd_ready  in  1  fabric accepts decision
hdr_err  out  1  one-cycle pulse: runt header or frame overrun
timeout_err  out  1  one-cycle pulse: WAIT timed out

Behaviour:
- Reset: all outputs 0, except ml_src_port=PORT_ID. MAC registers are 0, byte counter is 0, and the state is IDLE.
- States:
  - IDLE: on rx_valid&rx_sof, store the byte as dst_mac[47:40], set cnt=1, go to COLLECT. Non-sof bytes are ignored.
  - COLLECT: each valid byte is stored MSB-first. Bytes 0-5 go to dst_mac and bytes 6-11 go to src_mac. When the byte at cnt=11 is stored, go to REQ.
    - rx_eof before byte 11: pulse hdr_err, go to IDLE.
    - rx_sof mid-header: restart with the new byte as byte 0 and pulse hdr_err.
  - REQ: ml_src_mac and ml_dst_mac are held stable from entry until ml_done. If ml_busy=0, drive ml_en=1 for exactly one cycle and go to WAIT. Otherwise wait, with ml_en=0.
  - WAIT: timer increments each cycle.
    - On ml_done: latch ml_dst_port, go to PRESENT.
    - If timer reaches TIMEOUT first: pulse timeout_err, force flood, go to PRESENT.
    - An ml_done in the same cycle as the timeout wins; no timeout_err is raised.
  - PRESENT: fwd_valid=1 and fwd_* are held stable until fwd_valid&fwd_ready, then go to IDLE. The handshake completes in the same cycle that fwd_ready is sampled high.
- Decision priority:
  1. dst_mac[40]=1 (multicast/broadcast): flood.
  2. Result == MISS_PORT: flood.
  3. Result == PORT_ID: drop (hairpin).
  4. Otherwise: fwd_port=result.
  - When flood=1, fwd_port is set to PORT_ID. Exactly one of the three outcomes (flood, drop, unicast) applies.
- Frame body: bytes after byte 11 are ignored until rx_eof.
- rx_sof while in REQ, WAIT or PRESENT: the new frame gets no decision. Pulse hdr_err and ignore the frame through its eof; the current request completes normally.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; any in-flight request is abandoned and a late ml_done is ignored.
- ml_done outside WAIT is ignored.
- Latency: ml_en rises 1 cycle after byte 11 is accepted, given ml_busy=0. fwd_valid rises 1 cycle after ml_done.

Decomposition:
- Package mac_switch_pkg:
  - mac_t (logic [47:0]) and port_t (logic [2:0]).
  - Constants HDR_BYTES=12 and BCAST_MAC=48'hFFFF_FFFF_FFFF.
  - The req_state_t enum (IDLE, COLLECT, REQ, WAIT, PRESENT).
- One natural sub-module, mac_hdr_capture: the byte counter, MAC shift registers and hdr_err generation. The FSM and handshakes stay in the top.

Test Plan:
- Unicast hit: PORT_ID=2, frame dst 02:00:00:00:00:05, src 02:00:00:00:00:0A, 60 bytes, ml_busy=0, ml_done after 4 cycles with port 4 -> exactly one ml_en with correct MACs; fwd_valid with port=4, flood=0, drop=0, held until fwd_ready.
- Broadcast dst FF:FF:FF:FF:FF:FF with responder returning 3 -> fwd_flood=1, fwd_port=2; and a unicast dst with responder returning 7 -> flood=1.
- Hairpin: responder returns 2 for PORT_ID=2 -> fwd_drop=1.
- Busy hold-off: ml_busy high for 10 cycles after the header -> ml_en=0 throughout, then a single 1-cycle ml_en the cycle after busy falls; ml_src_mac stable throughout.
- Runt: eof on byte 7 -> hdr_err pulse, no ml_en, state returns to IDLE; a following valid frame is processed normally.
- Timeout: TIMEOUT=20 and ml_done never asserted -> timeout_err at cycle 20 of WAIT, flood decision presented. A separate case with ml_done coincident with the timeout -> no timeout_err. An rst_n pulse in WAIT -> all outputs 0.
